traffic_light: RTL and testbench
================================

# traffic_light

Per-lamp driver for one signal head in the intersection controller. It takes the 2-bit lamp code that the controller holds in its light-state register and drives exactly one of three active-high lamp outputs from registers. The controller inverts these outputs for the active-low LED board. Code 3 selects a flashing-yellow fault/maintenance mode with a built-in blink divider.

## Interface
Parameters:
- FLASH_HALF, default 25_000_000: clock cycles per half-period of the flashing yellow (0.5 s at 50 MHz); must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- state  input  2  lamp code: 0 = red, 1 = yellow, 2 = green, 3 = flashing yellow.
- green  output  1  green lamp, active-high, registered.
- yellow  output  1  yellow lamp, active-high, registered.
- red  output  1  red lamp, active-high, registered.

## Operation
- Outputs are one-hot, or all-zero during the dark half of flash mode. Two outputs are never high together.
- Code 0 gives red=1, yellow=0, green=0. Code 0 is also the safe default (all-red intersection).
- Code 1 gives yellow=1 only.
- Code 2 gives green=1 only.
- Code 3 gives red=0 and green=0, and yellow blinks:
  - On the first cycle code 3 is sampled, yellow=1 and the blink counter is cleared to 0.
  - The counter then increments every cycle. When it reaches FLASH_HALF-1, yellow toggles and the counter returns to 0.
  - Result: yellow is high for FLASH_HALF cycles, then low for FLASH_HALF cycles, repeating.
- Leaving code 3 clears the blink counter. Re-entering code 3 always starts with yellow on.
- Blink counter width is ceil(log2(FLASH_HALF)), with a minimum of 1 bit. It must never exceed FLASH_HALF-1.
- No sequencing checks are made. Any code-to-code change, including green→red directly, is applied as commanded. Timing between phases is the controller's responsibility.
- Input state is assumed synchronous to clk. No input synchronizer is required.

## Timing
- Outputs change on the first rising clk edge after state changes (1-cycle latency). No combinational path runs from state to the outputs.
- Reset values while reset=1: red=1, yellow=0, green=0, blink counter 0.
  - The asynchronous assertion forces these immediately, without waiting for a clock edge.
  - After reset is released, the first rising edge loads the decode of the current state.
- Reset asserted mid-flash or mid-green gives immediate red. Flash phase restarts with yellow on if code 3 is still present after release.
- Flash toggle lands exactly FLASH_HALF cycles after the previous toggle, or after the entry edge.
- With FLASH_HALF=1, yellow toggles every cycle while code 3 is held.

## Test plan
- Reset: hold reset=1 with state=2, then release. Required: red=1, green=0 during reset, changing asynchronously. After the first edge: green=1, red=0.
- Static decode: apply state 0, 1, 2 for 3 cycles each. Required: (r,y,g) = (1,0,0), (0,1,0), (0,0,1), each appearing one edge after the change.
- Flash (FLASH_HALF=4): hold state=3 for 20 cycles. Required: yellow pattern 1111 0000 1111 0000 from the first sampled edge, with red=green=0 throughout.
- Flash re-entry: state=3 for 6 cycles (yellow off at cycle 5-6), then state=0 for 1 cycle, then state=3. Required: red pulse for 1 cycle, then yellow=1 for a fresh 4 cycles.
- Async reset mid-flash: assert reset between clock edges while yellow=1. Required: yellow=0 and red=1 before the next edge.
- Controller pattern: drive codes 2→1→0→2 with cycle-accurate durations 5, 6, 20, 5. Required: each lamp is high for the same durations, delayed 1 cycle, and is never overlapping another lamp.

Source files
------------

// File: rtl/traffic_light.sv
// Registered lamp driver for one signal head: decodes the 2-bit lamp code
// into one-hot red/yellow/green, with a self-timed flashing-yellow mode.
`timescale 1ns/1ps

module traffic_light #(
  parameter int FLASH_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  output logic       green,
  output logic       yellow,
  output logic       red
);

  localparam int CNT_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_HALF - 1);

  typedef enum logic [1:0] {
    CODE_RED    = 2'd0,
    CODE_YELLOW = 2'd1,
    CODE_GREEN  = 2'd2,
    CODE_FLASH  = 2'd3
  } lamp_code_t;

  typedef enum logic {
    MODE_STEADY = 1'b0,
    MODE_FLASH  = 1'b1
  } mode_t;

  lamp_code_t       code;
  mode_t            mode, mode_nxt;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;
  logic             red_nxt, yellow_nxt, green_nxt;

  assign code = lamp_code_t'(state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode      <= MODE_STEADY;
      blink_cnt <= '0;
      red       <= 1'b1;
      yellow    <= 1'b0;
      green     <= 1'b0;
    end else begin
      mode      <= mode_nxt;
      blink_cnt <= blink_cnt_nxt;
      red       <= red_nxt;
      yellow    <= yellow_nxt;
      green     <= green_nxt;
    end
  end

  // Any code other than flash drops back to steady mode with the counter
  // cleared, so the next flash entry always starts in the lit half.
  always_comb begin
    mode_nxt      = MODE_STEADY;
    blink_cnt_nxt = '0;
    red_nxt       = 1'b0;
    yellow_nxt    = 1'b0;
    green_nxt     = 1'b0;
    case (code)
      CODE_YELLOW: yellow_nxt = 1'b1;
      CODE_GREEN:  green_nxt  = 1'b1;
      CODE_FLASH: begin
        mode_nxt = MODE_FLASH;
        if (mode == MODE_STEADY) begin
          yellow_nxt = 1'b1;
        end else if (blink_cnt == CNT_MAX) begin
          yellow_nxt = ~yellow;
        end else begin
          yellow_nxt    = yellow;
          blink_cnt_nxt = blink_cnt + 1'b1;
        end
      end
      default:     red_nxt    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Scenario bench for traffic_light with FLASH_HALF=4: expected lamp vectors
// {red,yellow,green} are queued as codes are driven and checked after each edge.
`timescale 1ns/1ps

module tb_traffic_light;

  localparam int FH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state;
  logic       green, yellow, red;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         flash_n = 0;
  logic [2:0] sb[$];
  logic [2:0] last_exp = 3'b100;

  traffic_light #(.FLASH_HALF(FH)) dut (
    .clk    (clk),
    .reset  (reset),
    .state  (state),
    .green  (green),
    .yellow (yellow),
    .red    (red)
  );

  always #5 clk = ~clk;

  // Reference: in flash, yellow is lit in even-numbered blocks of FH cycles
  // counted from the entry edge.
  task automatic drive(input logic [1:0] c);
    logic [2:0] e;
    state = c;
    case (c)
      2'd0: e = 3'b100;
      2'd1: e = 3'b010;
      2'd2: e = 3'b001;
      default: e = {1'b0, ((flash_n / FH) % 2) == 0, 1'b0};
    endcase
    if (c == 2'd3) flash_n++;
    else flash_n = 0;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic [2:0] e;
    reset = 1'b1;
    state = 2'd2;
    #3;
    n_tests++;
    if ({red, yellow, green} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_async_init got=%b want=100", {red, yellow, green});
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({red, yellow, green} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_hold got=%b want=100", {red, yellow, green});
    end
    reset = 1'b0;
    flash_n = 0;
    for (int n = 0; n < 2; n++) begin
      drive(2'd2);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      last_exp = e;
      n_tests++;
      if ({red, yellow, green} !== e) begin
        n_fail++;
        $display("FAIL reset_first_edge cyc=%0d got=%b want=%b", n, {red, yellow, green}, e);
      end
    end
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if ({red, yellow, green} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_async_green got=%b want=100", {red, yellow, green});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    flash_n = 0;
    last_exp = 3'b100;
  endtask

  task automatic test_static();
    logic [2:0] e;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 3; n++) begin
        drive(k[1:0]);
        #2;
        n_tests++;
        if ({red, yellow, green} !== last_exp) begin
          n_fail++;
          $display("FAIL static_latency code=%0d got=%b want=%b", k, {red, yellow, green}, last_exp);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        last_exp = e;
        n_tests++;
        if ({red, yellow, green} !== e) begin
          n_fail++;
          $display("FAIL static_decode code=%0d cyc=%0d got=%b want=%b", k, n, {red, yellow, green}, e);
        end
      end
    end
  endtask

  task automatic test_flash();
    logic [2:0] e;
    for (int n = 0; n < 20; n++) begin
      drive(2'd3);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      last_exp = e;
      n_tests++;
      if ({red, yellow, green} !== e) begin
        n_fail++;
        $display("FAIL flash_pattern cyc=%0d got=%b want=%b", n, {red, yellow, green}, e);
      end
    end
  endtask

  task automatic test_flash_reentry();
    logic [2:0] e;
    logic [1:0] codes[13];
    codes = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0,
              2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int n = 0; n < 13; n++) begin
      drive(codes[n]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      last_exp = e;
      n_tests++;
      if ({red, yellow, green} !== e) begin
        n_fail++;
        $display("FAIL flash_reentry cyc=%0d got=%b want=%b", n, {red, yellow, green}, e);
      end
    end
  endtask

  task automatic test_reset_mid_flash();
    logic [2:0] e;
    drive(2'd0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_tests++;
    if ({red, yellow, green} !== e) begin
      n_fail++;
      $display("FAIL midflash_pre got=%b want=%b", {red, yellow, green}, e);
    end
    for (int n = 0; n < 2; n++) begin
      drive(2'd3);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({red, yellow, green} !== e) begin
        n_fail++;
        $display("FAIL midflash_on cyc=%0d got=%b want=%b", n, {red, yellow, green}, e);
      end
    end
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if ({red, yellow, green} !== 3'b100) begin
      n_fail++;
      $display("FAIL midflash_async got=%b want=100", {red, yellow, green});
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({red, yellow, green} !== 3'b100) begin
      n_fail++;
      $display("FAIL midflash_held got=%b want=100", {red, yellow, green});
    end
    reset = 1'b0;
    flash_n = 0;
    for (int n = 0; n < 6; n++) begin
      drive(2'd3);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      last_exp = e;
      n_tests++;
      if ({red, yellow, green} !== e) begin
        n_fail++;
        $display("FAIL midflash_restart cyc=%0d got=%b want=%b", n, {red, yellow, green}, e);
      end
    end
  endtask

  task automatic test_controller_pattern();
    logic [2:0] e;
    logic [1:0] codes[4];
    int         lens[4];
    int         hi_cnt[3];
    codes = '{2'd2, 2'd1, 2'd0, 2'd2};
    lens  = '{5, 6, 20, 5};
    hi_cnt = '{0, 0, 0};
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < lens[p]; n++) begin
        drive(codes[p]);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        last_exp = e;
        if (red)    hi_cnt[0]++;
        if (yellow) hi_cnt[1]++;
        if (green)  hi_cnt[2]++;
        n_tests++;
        if ({red, yellow, green} !== e) begin
          n_fail++;
          $display("FAIL ctrl_pattern phase=%0d cyc=%0d got=%b want=%b", p, n, {red, yellow, green}, e);
        end
      end
    end
    n_tests++;
    if (hi_cnt[0] != 20 || hi_cnt[1] != 6 || hi_cnt[2] != 10) begin
      n_fail++;
      $display("FAIL ctrl_durations got r=%0d y=%0d g=%0d want r=20 y=6 g=10",
               hi_cnt[0], hi_cnt[1], hi_cnt[2]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_static();
    test_flash();
    test_flash_reentry();
    test_reset_mid_flash();
    test_controller_pattern();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
